cam_blk_reader: RTL and testbench



---
 rtl/cam_blk_reader.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_cam_blk_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_blk_reader.sv
// rtl/cam_blk_reader.sv - camera line buffer stripe reader emitting 8x8 block rows; CAMRD_YUV422_EN selects 4:2:2 MCU ordering
module cam_blk_reader #(
  parameter int unsigned LINE_WORDS = 240,
  parameter int unsigned AW         = 14,
  parameter int unsigned PW         = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cam_pic_start_f,
  input  logic          camfifo_o_f,
  input  logic [PW-1:0] PicWidth_i,
  input  logic [PW-1:0] PicHeight_i,
  output logic          cena_cambuf,
  output logic [AW-1:0] aa_cambuf,
  input  logic [63:0]   qa_cambuf,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic [63:0]   blk_data,
  output logic          blk_first,
  output logic [1:0]    blk_comp,
  output logic          blk_pic_last,
  output logic          ovf_err
);

  localparam logic [AW-1:0] LW     = AW'(LINE_WORDS);
  localparam logic [AW-1:0] U_BASE = AW'(16 * LINE_WORDS);
`ifdef CAMRD_YUV422_EN
  localparam logic [AW-1:0] V_BASE   = AW'(24 * LINE_WORDS);
  localparam logic [1:0]    LAST_SUB = 2'd3;
`else
  localparam logic [AW-1:0] V_BASE   = AW'(32 * LINE_WORDS);
  localparam logic [1:0]    LAST_SUB = 2'd2;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        first;
    logic [1:0]  comp;
    logic        last;
  } beat_t;

  state_t        state_q, state_d;
  logic [PW-1:0] x_q, x_d;
  logic [1:0]    sub_q, sub_d;
  logic [2:0]    r_q, r_d;
  logic          h_q;
  logic [PW-1:0] stripe_q;
  logic [1:0]    pend_q;
  logic          ovf_q;
  logic [AW-1:0] aa_q;

  logic          rdv_q;
  logic          rd_first_q;
  logic [1:0]    rd_comp_q;
  logic          rd_last_q;

  beat_t         fifo_q [2];
  logic          wr_q;
  logic          rd_q;
  logic [1:0]    cnt_q;

  logic [PW-1:0] ncol, ncol_m1, nstripe, nstripe_m1;
  logic [2:0]    lrows_m1;
  logic          last_stripe;
  logic          last_issue;
  logic          credit_ok;
  logic          issue;
  logic          fin_done;
  logic          pop;
  logic [2:0]    used;
  logic [1:0]    cur_comp;

  // Picture geometry: block columns (or MCUs), stripes and valid rows in the bottom stripe
`ifdef CAMRD_YUV422_EN
  assign ncol = (PicWidth_i >> 4) + PW'(PicWidth_i[3:0] != 4'd0);
`else
  assign ncol = (PicWidth_i >> 3) + PW'(PicWidth_i[2:0] != 3'd0);
`endif
  assign nstripe    = (PicHeight_i >> 3) + PW'(PicHeight_i[2:0] != 3'd0);
  assign ncol_m1    = ncol - PW'(1);
  assign nstripe_m1 = nstripe - PW'(1);
  assign lrows_m1   = PicHeight_i[2:0] - 3'd1;

  assign last_stripe = (stripe_q == nstripe_m1);
  assign last_issue  = (r_q == 3'd7) && (sub_q == LAST_SUB) && (x_q == ncol_m1);

  // The in-flight read plus what stays in the FIFO after this cycle's pop must fit in two entries
  assign blk_valid = (cnt_q != 2'd0);
  assign pop       = blk_valid & blk_ready;
  assign used      = {1'b0, cnt_q} + {2'b0, rdv_q};
  assign credit_ok = used < (3'd2 + {2'b0, pop});

`ifdef CAMRD_YUV422_EN
  assign cur_comp = sub_q[1] ? (sub_q - 2'd1) : 2'd0;
`else
  assign cur_comp = sub_q;
`endif

  function automatic logic [AW-1:0] rd_addr(
    input logic [PW-1:0] x,
    input logic [1:0]    sub,
    input logic [2:0]    r,
    input logic          h,
    input logic          lst,
    input logic [2:0]    lrm1
  );
    logic [2:0]    rr;
    logic [AW-1:0] base;
    logic [PW-1:0] col;
    // Rows below the picture bottom repeat the last valid line
    rr   = (lst && (r > lrm1)) ? lrm1 : r;
    base = '0;
    col  = x;
`ifdef CAMRD_YUV422_EN
    case (sub)
      2'd0:    col  = {x[PW-2:0], 1'b0};
      2'd1:    col  = {x[PW-2:0], 1'b1};
      2'd2:    base = U_BASE;
      default: base = V_BASE;
    endcase
`else
    case (sub)
      2'd1:    base = U_BASE;
      2'd2:    base = V_BASE;
      default: base = '0;
    endcase
`endif
    return base + LW * AW'({h, rr}) + AW'(col);
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state, read issue and stripe completion
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    fin_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q != 2'd0) state_d = S_RUN;
      end
      S_RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (last_issue) state_d = S_FIN;
        end
      end
      S_FIN: begin
        if ((cnt_q == 2'd0) && !rdv_q) begin
          fin_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cam_pic_start_f) begin
      state_d  = S_IDLE;
      fin_done = 1'b0;
    end
  end

  // Walk order: row innermost, then component slot, then column; wraps after the last read
  always_comb begin
    r_d   = r_q + 3'd1;
    sub_d = sub_q;
    x_d   = x_q;
    if (r_q == 3'd7) begin
      if (sub_q == LAST_SUB) begin
        sub_d = 2'd0;
        x_d   = last_issue ? '0 : x_q + PW'(1);
      end else begin
        sub_d = sub_q + 2'd1;
      end
    end
  end

  assign cena_cambuf = ~issue;
  assign aa_cambuf   = aa_q;

  // Walk counters, half/stripe tracking and the prepared address of the next read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q      <= '0;
      sub_q    <= '0;
      r_q      <= '0;
      h_q      <= 1'b0;
      stripe_q <= '0;
      aa_q     <= '0;
    end else if (cam_pic_start_f) begin
      x_q      <= '0;
      sub_q    <= '0;
      r_q      <= '0;
      h_q      <= 1'b0;
      stripe_q <= '0;
      aa_q     <= '0;
    end else begin
      if (issue) begin
        x_q   <= x_d;
        sub_q <= sub_d;
        r_q   <= r_d;
        // After the final read the next stripe starts in the other half
        aa_q  <= rd_addr(x_d, sub_d, r_d, last_issue ? ~h_q : h_q, last_stripe, lrows_m1);
      end
      if (fin_done) begin
        h_q      <= ~h_q;
        stripe_q <= last_stripe ? '0 : stripe_q + PW'(1);
      end
    end
  end

  // Sideband for the read whose data returns next cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdv_q      <= 1'b0;
      rd_first_q <= 1'b0;
      rd_comp_q  <= 2'd0;
      rd_last_q  <= 1'b0;
    end else begin
      rdv_q <= issue & ~cam_pic_start_f;
      if (issue) begin
        rd_first_q <= (r_q == 3'd0);
        rd_comp_q  <= cur_comp;
        rd_last_q  <= last_issue & last_stripe;
      end
    end
  end

  // Two-entry skid FIFO; returned data is dropped across a picture start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (cam_pic_start_f) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (rdv_q) begin
        fifo_q[wr_q] <= {qa_cambuf, rd_first_q, rd_comp_q, rd_last_q};
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, rdv_q} - {1'b0, pop};
    end
  end

  assign blk_data     = fifo_q[rd_q].data;
  assign blk_first    = fifo_q[rd_q].first;
  assign blk_comp     = fifo_q[rd_q].comp;
  assign blk_pic_last = fifo_q[rd_q].last;
  assign ovf_err      = ovf_q;

  // Pending-stripe counter with sticky overflow; a flag coinciding with picture start survives the clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= 2'd0;
      ovf_q  <= 1'b0;
    end else if (cam_pic_start_f) begin
      pend_q <= {1'b0, camfifo_o_f};
      ovf_q  <= 1'b0;
    end else if (camfifo_o_f && !fin_done) begin
      if (pend_q == 2'd2) ovf_q <= 1'b1;
      else                pend_q <= pend_q + 2'd1;
    end else if (!camfifo_o_f && fin_done) begin
      pend_q <= pend_q - 2'd1;
    end
  end

endmodule

// File: tb/tb_cam_blk_reader.sv
// tb/tb_cam_blk_reader.sv - scoreboard bench for cam_blk_reader
module tb_cam_blk_reader;

  localparam int LW = 4;
  localparam int AW = 14;
  localparam int PW = 12;

  typedef struct {
    logic [63:0] data;
    logic        first;
    logic [1:0]  comp;
    logic        last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cam_pic_start_f = 1'b0;
  logic          camfifo_o_f = 1'b0;
  logic [PW-1:0] PicWidth_i = '0;
  logic [PW-1:0] PicHeight_i = '0;
  logic          cena_cambuf;
  logic [AW-1:0] aa_cambuf;
  logic [63:0]   qa_cambuf = '0;
  logic          blk_valid;
  logic          blk_ready = 1'b1;
  logic [63:0]   blk_data;
  logic          blk_first;
  logic [1:0]    blk_comp;
  logic          blk_pic_last;
  logic          ovf_err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   pic_w, pic_h, m_h, m_stripe;
  bit   rnd_ready = 0;
  int   lat;

  cam_blk_reader #(.LINE_WORDS(LW), .AW(AW), .PW(PW)) dut (
    .clk(clk), .rstn(rstn), .cam_pic_start_f(cam_pic_start_f), .camfifo_o_f(camfifo_o_f),
    .PicWidth_i(PicWidth_i), .PicHeight_i(PicHeight_i), .cena_cambuf(cena_cambuf),
    .aa_cambuf(aa_cambuf), .qa_cambuf(qa_cambuf), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_first(blk_first), .blk_comp(blk_comp),
    .blk_pic_last(blk_pic_last), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word_of(input int a);
    return {32'hCAFE0000 | a, a};
  endfunction

  // line buffer: each word holds its own address
  always @(posedge clk) if (!cena_cambuf) qa_cambuf <= word_of(int'(aa_cambuf));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void push_stripe();
    int ncol, nstr, lrows, rr, nsub, xx, base, comp, addr;
    bit last;
    exp_t e;
    nstr  = (pic_h + 7) / 8;
    lrows = ((pic_h - 1) % 8) + 1;
    last  = (m_stripe == nstr - 1);
`ifdef CAMRD_YUV422_EN
    ncol = (pic_w + 15) / 16;
    nsub = 4;
`else
    ncol = (pic_w + 7) / 8;
    nsub = 3;
`endif
    for (int x = 0; x < ncol; x++)
      for (int s = 0; s < nsub; s++)
        for (int r = 0; r < 8; r++) begin
          rr = (last && r >= lrows) ? lrows - 1 : r;
`ifdef CAMRD_YUV422_EN
          xx   = (s < 2) ? 2 * x + s : x;
          base = (s == 2) ? 16 * LW : (s == 3) ? 24 * LW : 0;
          comp = (s < 2) ? 0 : s - 1;
`else
          xx   = x;
          base = s * 16 * LW;
          comp = s;
`endif
          addr    = base + LW * (8 * m_h + rr) + xx;
          e.data  = word_of(addr);
          e.first = (r == 0);
          e.comp  = comp[1:0];
          e.last  = last && (x == ncol - 1) && (s == nsub - 1) && (r == 7);
          sb.push_back(e);
        end
    m_h      = m_h ^ 1;
    m_stripe = last ? 0 : m_stripe + 1;
  endfunction

  task automatic set_pic(input int w, input int h);
    pic_w       = w;
    pic_h       = h;
    PicWidth_i  = PW'(w);
    PicHeight_i = PW'(h);
  endtask

  task automatic pic_start();
    @(posedge clk); #1;
    cam_pic_start_f = 1'b1;
    sb.delete();
    m_h      = 0;
    m_stripe = 0;
    @(posedge clk); #1;
    cam_pic_start_f = 1'b0;
  endtask

  task automatic flag(input bit expect_beats);
    @(posedge clk); #1;
    camfifo_o_f = 1'b1;
    if (expect_beats) push_stripe();
    @(posedge clk); #1;
    camfifo_o_f = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, 64'(sb.size()), 64'd0);
    repeat (12) @(posedge clk);
  endtask

  // random back-pressure
  initial begin : ready_drv
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) blk_ready = 1'($urandom_range(0, 1));
    end
  end

  // output monitor: scoreboard pops on handshake, stability while stalled
  initial begin : monitor
    exp_t        e;
    bit          stall;
    logic [67:0] held;
    stall = 0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (stall) begin
          check_eq("stall_valid", 64'(blk_valid), 64'd1);
          check_eq("stall_hold", 64'({blk_data[59:0], blk_first, blk_comp, blk_pic_last}), 64'(held));
        end
        if (blk_valid && blk_ready) begin
          check_eq("beat_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("beat_data", blk_data, e.data);
            check_eq("beat_first", 64'(blk_first), 64'(e.first));
            check_eq("beat_comp", 64'(blk_comp), 64'(e.comp));
            check_eq("beat_pic_last", 64'(blk_pic_last), 64'(e.last));
          end
        end
        stall = blk_valid && !blk_ready && !cam_pic_start_f;
        held  = {blk_data, blk_first, blk_comp, blk_pic_last};
      end
    end
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cena", 64'(cena_cambuf), 64'd1);
    check_eq("rst_aa", 64'(aa_cambuf), 64'd0);
    check_eq("rst_valid", 64'(blk_valid), 64'd0);
    check_eq("rst_data", blk_data, 64'd0);
    check_eq("rst_first", 64'(blk_first), 64'd0);
    check_eq("rst_comp", 64'(blk_comp), 64'd0);
    check_eq("rst_pic_last", 64'(blk_pic_last), 64'd0);
    check_eq("rst_ovf", 64'(ovf_err), 64'd0);
    rstn = 1'b1;

`ifdef CAMRD_YUV422_EN
    set_pic(32, 8);
`else
    set_pic(16, 8);
`endif
    pic_start();
    // single stripe, ready high, first-beat latency
    @(posedge clk); #1;
    camfifo_o_f = 1'b1;
    push_stripe();
    lat = 0;
    do begin
      @(posedge clk); #1;
      camfifo_o_f = 1'b0;
      lat++;
    end while (!blk_valid && lat < 20);
    check_eq("first_valid_lat", 64'(lat), 64'd4);
    drain("drain_single", 2000);

    // two stripes, second from the upper half
    set_pic(16, 16);
    pic_start();
    flag(1);
    repeat (5) @(posedge clk);
    flag(1);
    drain("drain_h16", 3000);

    // short last stripe under random back-pressure
    set_pic(16, 12);
    pic_start();
    rnd_ready = 1;
    flag(1);
    flag(1);
    drain("drain_h12_rnd", 4000);

    // wider picture, random back-pressure
    set_pic(24, 16);
    pic_start();
    flag(1);
    repeat (40) @(posedge clk);
    flag(1);
    drain("drain_w24_rnd", 6000);
    rnd_ready = 0;
    @(posedge clk); #1;
    blk_ready = 1'b1;

    // overflow with no stripe able to finish, then restart with a coincident flag
    set_pic(16, 8);
    pic_start();
    @(posedge clk); #1;
    blk_ready = 1'b0;
    flag(0);
    flag(0);
    flag(0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("ovf_pending", 64'(dut.pend_q), 64'd2);
    check_eq("ovf_set", 64'(ovf_err), 64'd1);
    @(posedge clk); #1;
    cam_pic_start_f = 1'b1;
    camfifo_o_f     = 1'b1;
    sb.delete();
    m_h      = 0;
    m_stripe = 0;
    push_stripe();
    @(posedge clk); #1;
    cam_pic_start_f = 1'b0;
    camfifo_o_f     = 1'b0;
    check_eq("restart_ovf", 64'(ovf_err), 64'd0);
    check_eq("restart_pending", 64'(dut.pend_q), 64'd1);
    blk_ready = 1'b1;
    drain("drain_restart", 2000);
    check_eq("idle_pending", 64'(dut.pend_q), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
